writeback_stage: RTL and testbench

EX/WB pipeline register, 8×8 register file, writeback and forwarding unit for the 4-stage 8-bit pipeline. Captures the execute stage's ALU result, destination register and write enable each cycle. Commits the result to the register file one cycle later and serves the decode-stage register read. Generates the forward select and forward data that the execute stage uses to resolve back-to-back RAW hazards.

---
 rtl/writeback_stage.sv | 107 ++++++++++
 tb/tb_writeback_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// EX/WB pipeline register, 8x8 register file, writeback and RAW forwarding for the 4-stage 8-bit pipeline.
// Optional build macro WB_READ_BYPASS_EN: decode read returns the WB write data when it targets the read address.
module writeback_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_valid,
  input  logic              flush,
  input  logic [ADDR_W-1:0] ex_src_reg,
  input  logic [ADDR_W-1:0] id_rd_addr,
  output logic [DATA_W-1:0] id_rd_data,
  output logic [ADDR_W-1:0] wb_rd,
  output logic              wb_reg_write,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd_ctrl,
  output logic [15:0]       commit_count
);

  logic              wb_valid_q, wb_valid_d;
  logic              wb_we_raw_q, wb_we_raw_d;
  logic [ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [15:0]       commit_count_q, commit_count_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wb_reg_write_s;

  assign wb_reg_write_s = wb_valid_q & wb_we_raw_q;

  // EX/WB capture: the stage never stalls, flush turns the entry into a bubble
  always_comb begin
    wb_valid_d  = ex_valid & ~flush;
    wb_we_raw_d = ex_reg_write;
    wb_rd_d     = ex_rd;
    wb_data_d   = ex_alu_out;
  end

  // Register file and commit counter next-state
  always_comb begin
    regs_d         = regs_q;
    commit_count_d = commit_count_q;
    if (wb_reg_write_s) begin
      regs_d[wb_rd_q] = wb_data_q;
      commit_count_d  = commit_count_q + 16'd1;
    end else begin
      regs_d         = regs_q;
      commit_count_d = commit_count_q;
    end
  end

  // State registers; reset discards any in-flight write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q     <= 1'b0;
      wb_we_raw_q    <= 1'b0;
      wb_rd_q        <= {ADDR_W{1'b0}};
      wb_data_q      <= {DATA_W{1'b0}};
      commit_count_q <= 16'd0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_we_raw_q    <= wb_we_raw_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      commit_count_q <= commit_count_d;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Decode read port
  always_comb begin
`ifdef WB_READ_BYPASS_EN
    if (wb_reg_write_s && (wb_rd_q == id_rd_addr)) begin
      id_rd_data = wb_data_q;
    end else begin
      id_rd_data = regs_q[id_rd_addr];
    end
`else
    id_rd_data = regs_q[id_rd_addr];
`endif
  end

  // Forward select for the EX operand mux
  always_comb begin
    if (wb_reg_write_s && (wb_rd_q == ex_src_reg)) begin
      fwd_ctrl = 1'b1;
    end else begin
      fwd_ctrl = 1'b0;
    end
  end

  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_s;
  assign wb_data      = wb_data_q;
  assign commit_count = commit_count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Table-driven directed bench for writeback_stage plus hand-written reset, wrap sequences.
module tb_writeback_stage;

  logic       clk;
  logic       rst_n;
  logic [7:0] ex_alu_out;
  logic [2:0] ex_rd;
  logic       ex_reg_write;
  logic       ex_valid;
  logic       flush;
  logic [2:0] ex_src_reg;
  logic [2:0] id_rd_addr;
  logic [7:0] id_rd_data;
  logic [2:0] wb_rd;
  logic       wb_reg_write;
  logic [7:0] wb_data;
  logic       fwd_ctrl;
  logic [15:0] commit_count;

  int pass_cnt;
  int total_cnt;

`ifdef WB_READ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [7:0]  alu;
    logic [2:0]  rd;
    logic        we;
    logic        valid;
    logic        fl;
    logic [2:0]  src;
    logic [2:0]  raddr;
    logic [2:0]  exp_wb_rd;
    logic        exp_wb_rw;
    logic [7:0]  exp_wb_data;
    logic        exp_fwd;
    logic [7:0]  exp_id_nb;
    logic [7:0]  exp_id_bp;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [9];

  writeback_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_alu_out   (ex_alu_out),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_valid     (ex_valid),
    .flush        (flush),
    .ex_src_reg   (ex_src_reg),
    .id_rd_addr   (id_rd_addr),
    .id_rd_data   (id_rd_data),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .wb_data      (wb_data),
    .fwd_ctrl     (fwd_ctrl),
    .commit_count (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] alu, input logic [2:0] rd, input logic we,
                       input logic v, input logic fl, input logic [2:0] src, input logic [2:0] ra);
    ex_alu_out   = alu;
    ex_rd        = rd;
    ex_reg_write = we;
    ex_valid     = v;
    flush        = fl;
    ex_src_reg   = src;
    id_rd_addr   = ra;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    drive(8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);

    //          alu    rd    we    v     fl    src   raddr  wb_rd rw    data   fwd   id_nb  id_bp  cnt
    vecs[0] = '{8'h3C, 3'd5, 1'b1, 1'b1, 1'b0, 3'd5, 3'd5, 3'd5, 1'b1, 8'h3C, 1'b1, 8'h00, 8'h3C, 16'd0};
    vecs[1] = '{8'hA7, 3'd2, 1'b1, 1'b1, 1'b0, 3'd2, 3'd5, 3'd2, 1'b1, 8'hA7, 1'b1, 8'h3C, 8'h3C, 16'd1};
    vecs[2] = '{8'hFF, 3'd1, 1'b1, 1'b1, 1'b1, 3'd1, 3'd2, 3'd1, 1'b0, 8'hFF, 1'b0, 8'hA7, 8'hA7, 16'd2};
    vecs[3] = '{8'h11, 3'd3, 1'b0, 1'b1, 1'b0, 3'd3, 3'd1, 3'd3, 1'b0, 8'h11, 1'b0, 8'h00, 8'h00, 16'd2};
    vecs[4] = '{8'h81, 3'd6, 1'b1, 1'b1, 1'b0, 3'd6, 3'd6, 3'd6, 1'b1, 8'h81, 1'b1, 8'h00, 8'h81, 16'd2};
    vecs[5] = '{8'h42, 3'd6, 1'b1, 1'b0, 1'b0, 3'd6, 3'd6, 3'd6, 1'b0, 8'h42, 1'b0, 8'h81, 8'h81, 16'd3};
    vecs[6] = '{8'h5A, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 8'h5A, 1'b1, 8'h00, 8'h5A, 16'd3};
    vecs[7] = '{8'hC3, 3'd3, 1'b1, 1'b1, 1'b0, 3'd4, 3'd0, 3'd3, 1'b1, 8'hC3, 1'b0, 8'h5A, 8'h5A, 16'd4};
    vecs[8] = '{8'h00, 3'd7, 1'b0, 1'b0, 1'b0, 3'd3, 3'd3, 3'd7, 1'b0, 8'h00, 1'b0, 8'hC3, 8'hC3, 16'd5};

    #1;
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_rw", 32'(wb_reg_write), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_fwd", 32'(fwd_ctrl), 32'd0);
    chk("rst_id", 32'(id_rd_data), 32'd0);
    chk("rst_cnt", 32'(commit_count), 32'd0);
    #11;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].alu, vecs[i].rd, vecs[i].we, vecs[i].valid, vecs[i].fl, vecs[i].src, vecs[i].raddr);
      tick();
      chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd), 32'(vecs[i].exp_wb_rd));
      chk($sformatf("v%0d_wb_rw", i), 32'(wb_reg_write), 32'(vecs[i].exp_wb_rw));
      chk($sformatf("v%0d_wb_data", i), 32'(wb_data), 32'(vecs[i].exp_wb_data));
      chk($sformatf("v%0d_fwd", i), 32'(fwd_ctrl), 32'(vecs[i].exp_fwd));
      chk($sformatf("v%0d_id", i), 32'(id_rd_data),
          BYPASS ? 32'(vecs[i].exp_id_bp) : 32'(vecs[i].exp_id_nb));
      chk($sformatf("v%0d_cnt", i), 32'(commit_count), 32'(vecs[i].exp_cnt));
    end

    // Earlier results must still be architecturally visible
    drive(8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd5);
    #1;
    chk("hold_r5", 32'(id_rd_data), 32'h3C);
    id_rd_addr = 3'd1;
    #1;
    chk("flush_r1_unchanged", 32'(id_rd_data), 32'h00);

    // Mid-run reset with a write in flight
    tick();
    drive(8'h5A, 3'd3, 1'b1, 1'b1, 1'b0, 3'd3, 3'd3);
    tick();
    drive(8'h77, 3'd3, 1'b1, 1'b1, 1'b0, 3'd3, 3'd3);
    tick();
    chk("mr_pre_cnt", 32'(commit_count), 32'd6);
    chk("mr_pre_fwd", 32'(fwd_ctrl), 32'd1);
    chk("mr_pre_id", 32'(id_rd_data), BYPASS ? 32'h77 : 32'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_id", 32'(id_rd_data), 32'd0);
    chk("mr_cnt", 32'(commit_count), 32'd0);
    chk("mr_fwd", 32'(fwd_ctrl), 32'd0);
    chk("mr_rw", 32'(wb_reg_write), 32'd0);
    drive(8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3, 3'd3);
    #2;
    rst_n = 1'b1;
    tick();
    chk("mr_discard_r3", 32'(id_rd_data), 32'd0);
    chk("mr_discard_cnt", 32'(commit_count), 32'd0);

    // Counter wrap after 65536 commits
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] iv;
      iv = 16'(i);
      drive(iv[7:0], iv[2:0], 1'b1, 1'b1, 1'b0, 3'd0, 3'd7);
      tick();
    end
    chk("wrap_ffff", 32'(commit_count), 32'hFFFF);
    drive(8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd7);
    tick();
    chk("wrap_zero", 32'(commit_count), 32'h0000);
    chk("wrap_r7", 32'(id_rd_data), 32'hFF);
    tick();
    chk("wrap_hold", 32'(commit_count), 32'h0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
